absorb_controller: RTL and testbench
====================================

# absorb_controller

Sequences the SHAKE absorb phase around the `padding_generator` datapath. It accepts message words from an upstream valid/ready stream and counts word positions within the rate block. It drives the generator's control inputs (`padding_enable`, `remaining_valid_bytes`, `last_word_in_block`, `padding_reset`) and emits padded words to the Keccak state. After each full block it starts and waits for the permutation, then reports completion so the squeeze controller can take over.

## Interface
Parameters:
- RATE_WORDS, default 21, number of w-bit words per rate block (21 = SHAKE128, 17 = SHAKE256); must be ≥2.

Ports (w, w_byte_width from keccak_pkg). One clock; reset is synchronous and active-high: `clk`, `rst`.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  controller accepts word this cycle
- in_data  in  w  message word; valid bytes occupy the most-significant byte lanes
- in_bytes  in  w_byte_width+1  valid bytes in word (0..8); sampled only when in_last=1
- in_last  in  1  final word of message
- pad_data_in  out  w  to generator data_in
- pad_remaining_bytes  out  w_byte_width+1  to generator remaining_valid_bytes
- pad_enable  out  1  to generator padding_enable
- pad_last_word  out  1  to generator last_word_in_block
- pad_reset  out  1  to generator padding_reset
- pad_data_out  in  w  from generator data_out
- absorb_valid  out  1  absorb_data to be XORed into state lane absorb_idx this cycle
- absorb_data  out  w  equals pad_data_out
- absorb_idx  out  $clog2(RATE_WORDS)  lane index within block
- perm_start  out  1  one-cycle permutation start pulse
- perm_done  in  1  permutation complete (one-cycle pulse)
- absorb_done  out  1  message fully absorbed; held until next_msg
- next_msg  in  1  release DONE, begin next message

## Operation
- States: ABSORB, PAD, PERM_START, PERM_WAIT, DONE. Registers: state, word_idx, pad_started, msg_ended.
- ABSORB: in_ready=1. On handshake: pad_data_in=in_data, absorb_valid=1, absorb_idx=word_idx.
  - Not last: pad_enable=0, pad_remaining_bytes=8.
  - in_last with in_bytes<8: pad_enable=1, pad_remaining_bytes=in_bytes, set pad_started and msg_ended.
  - in_last with in_bytes=8: pad_enable=0, set msg_ended, padding deferred to a full zero word.
- PAD: in_ready=0. Every cycle: pad_data_in=0, pad_remaining_bytes=0, pad_enable=1, absorb_valid=1, set pad_started.
- pad_last_word = (word_idx==RATE_WORDS-1) whenever absorb_valid=1.
- After an absorbed word:
  - If word_idx==RATE_WORDS-1: word_idx←0, go PERM_START.
  - Else word_idx+1. Next state is PAD if msg_ended, else stay in current state.
- PERM_START: perm_start=1 for one cycle, then PERM_WAIT.
- PERM_WAIT: on perm_done:
  - pad_started=1: go DONE.
  - msg_ended=1 and pad_started=0: go PAD (extra padding block).
  - Otherwise: go ABSORB.
- DONE: absorb_done=1, in_ready=0. On next_msg: pad_reset=1 that cycle, clear pad_started/msg_ended/word_idx, go ABSORB.
- in_bytes>8 is illegal and undefined. in_bytes=0 with in_last pads the whole word starting at byte 7.

## Timing
- Reset values: state ABSORB, word_idx 0, flags 0. Outputs: in_ready=1, absorb_valid=0, perm_start=0, absorb_done=0, pad_enable=0, pad_reset=1 during rst.
- in_ready is a function of state only; it never depends on in_valid.
- absorb_valid is combinational with the handshake, with zero latency through the generator.
- perm_start is asserted in the cycle after the word at idx RATE_WORDS-1.
- perm_done is ignored outside PERM_WAIT, including in the PERM_START cycle.
- perm_done→DONE/ABSORB/PAD transition takes one cycle.
- Full-block throughput: RATE_WORDS + 2 + permutation latency cycles.
- rst mid-operation (any state) aborts the message. The next word accepted is lane 0 of a new message.
- next_msg outside DONE is ignored.

## Test plan
- RATE_WORDS=21, single word in_bytes=3, in_last → lane0 bytes 7..5=data, byte4=0x1F, bytes3..0=0; lanes1..19=0; lane20 byte0=0x80; one perm_start; absorb_done after perm_done.
- 21 words, last word in_bytes=7 → lane20 byte0=0x9F; exactly one perm_start; DONE.
- 21 words, last word in_bytes=8 → block 1 unpadded; second block lane0 byte7=0x1F, lane20 byte0=0x80; two perm_starts.
- Random in_valid gaps plus in_valid held during PERM_WAIT → in_ready=0 in PERM_*/PAD/DONE. No word lost or duplicated; absorb_idx contiguous.
- rst asserted in PAD at word_idx=9 → next cycle in_ready=1, absorb_idx=0. Next message padded correctly.
- Two messages back-to-back via next_msg → pad_reset pulse seen. Second message's first padded byte is 0x1F (latch cleared).

Source files
------------

// File: rtl/absorb_controller.sv
// SHAKE absorb sequencer: feeds message words through the padding generator into
// the rate lanes, inserts padding-only words/blocks, and hands off to the permutation.
package keccak_pkg;
   localparam int W            = 64;
   localparam int W_BYTE_WIDTH = 3;
endpackage

module absorb_controller
   import keccak_pkg::*;
#(
   parameter int RATE_WORDS = 21,
   localparam int IDXW      = $clog2(RATE_WORDS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [W-1:0]            in_data,
   input  logic [W_BYTE_WIDTH:0]   in_bytes,
   input  logic                    in_last,
   output logic [W-1:0]            pad_data_in,
   output logic [W_BYTE_WIDTH:0]   pad_remaining_bytes,
   output logic                    pad_enable,
   output logic                    pad_last_word,
   output logic                    pad_reset,
   input  logic [W-1:0]            pad_data_out,
   output logic                    absorb_valid,
   output logic [W-1:0]            absorb_data,
   output logic [IDXW-1:0]         absorb_idx,
   output logic                    perm_start,
   input  logic                    perm_done,
   output logic                    absorb_done,
   input  logic                    next_msg
);

   localparam logic [IDXW-1:0]       LAST_IDX   = IDXW'(RATE_WORDS - 1);
   localparam logic [W_BYTE_WIDTH:0] FULL_BYTES = (W_BYTE_WIDTH + 1)'(W / 8);

   typedef enum logic [2:0] {
      S_ABSORB,
      S_PAD,
      S_PERM_START,
      S_PERM_WAIT,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [IDXW-1:0] r_word_idx;
   logic            r_pad_started;
   logic            r_msg_ended;

   logic w_hs;
   logic w_word;
   logic w_short_last;
   logic w_at_end;
   logic w_release;

   assign w_hs         = (r_state == S_ABSORB) && in_valid && !rst;
   assign w_word       = w_hs || ((r_state == S_PAD) && !rst);
   assign w_short_last = in_last && (in_bytes < FULL_BYTES);
   assign w_at_end     = (r_word_idx == LAST_IDX);
   assign w_release    = (r_state == S_DONE) && next_msg;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_ABSORB;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_word_idx    <= '0;
         r_pad_started <= 1'b0;
         r_msg_ended   <= 1'b0;
      end else if (w_release) begin
         r_word_idx    <= '0;
         r_pad_started <= 1'b0;
         r_msg_ended   <= 1'b0;
      end else begin
         if (w_word) begin
            r_word_idx <= w_at_end ? '0 : r_word_idx + 1'b1;
         end
         if (w_hs && in_last) begin
            r_msg_ended <= 1'b1;
            if (w_short_last) begin
               r_pad_started <= 1'b1;
            end
         end
         if (r_state == S_PAD) begin
            r_pad_started <= 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_ABSORB: begin
            if (w_hs) begin
               if (w_at_end)     w_state_nxt = S_PERM_START;
               else if (in_last) w_state_nxt = S_PAD;
            end
         end
         S_PAD: begin
            if (w_at_end) w_state_nxt = S_PERM_START;
         end
         S_PERM_START: w_state_nxt = S_PERM_WAIT;
         S_PERM_WAIT: begin
            // A full final word leaves padding for a fresh block.
            if (perm_done) begin
               if (r_pad_started)    w_state_nxt = S_DONE;
               else if (r_msg_ended) w_state_nxt = S_PAD;
               else                  w_state_nxt = S_ABSORB;
            end
         end
         S_DONE: begin
            if (next_msg) w_state_nxt = S_ABSORB;
         end
         default: w_state_nxt = S_ABSORB;
      endcase
   end

   always_comb begin
      in_ready            = rst || (r_state == S_ABSORB);
      absorb_valid        = w_word;
      absorb_data         = pad_data_out;
      absorb_idx          = r_word_idx;
      pad_data_in         = (r_state == S_PAD) ? '0 : in_data;
      pad_remaining_bytes = FULL_BYTES;
      if (r_state == S_PAD)  pad_remaining_bytes = '0;
      else if (in_last)      pad_remaining_bytes = in_bytes;
      pad_enable          = !rst && ((w_hs && w_short_last) || (r_state == S_PAD));
      pad_last_word       = w_word && w_at_end;
      pad_reset           = rst || w_release;
      perm_start          = !rst && (r_state == S_PERM_START);
      absorb_done         = !rst && (r_state == S_DONE);
   end

endmodule

// File: tb/tb_absorb_controller.sv
// Bench for absorb_controller: a padding-generator stand-in, a permutation responder,
// and a byte-stream SHAKE padding model predicting every absorbed lane.
module tb_absorb_controller;
   import keccak_pkg::*;

   localparam int RW   = 21;
   localparam int IDXW = $clog2(RW);
   localparam int RB   = RW * 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  in_valid;
   logic                  in_ready;
   logic [W-1:0]          in_data;
   logic [W_BYTE_WIDTH:0] in_bytes;
   logic                  in_last;
   logic [W-1:0]          pad_data_in;
   logic [W_BYTE_WIDTH:0] pad_remaining_bytes;
   logic                  pad_enable;
   logic                  pad_last_word;
   logic                  pad_reset;
   logic [W-1:0]          pad_data_out;
   logic                  absorb_valid;
   logic [W-1:0]          absorb_data;
   logic [IDXW-1:0]       absorb_idx;
   logic                  perm_start;
   logic                  perm_done;
   logic                  absorb_done;
   logic                  next_msg;

   absorb_controller #(.RATE_WORDS(RW)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_data             (in_data),
      .in_bytes            (in_bytes),
      .in_last             (in_last),
      .pad_data_in         (pad_data_in),
      .pad_remaining_bytes (pad_remaining_bytes),
      .pad_enable          (pad_enable),
      .pad_last_word       (pad_last_word),
      .pad_reset           (pad_reset),
      .pad_data_out        (pad_data_out),
      .absorb_valid        (absorb_valid),
      .absorb_data         (absorb_data),
      .absorb_idx          (absorb_idx),
      .perm_start          (perm_start),
      .perm_done           (perm_done),
      .absorb_done         (absorb_done),
      .next_msg            (next_msg)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_perm   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Generator stand-in: keeps valid bytes, inserts 0x1F once per message, 0x80 on block end.
   logic gen_latched;
   always_comb begin
      pad_data_out = '0;
      for (int p = 0; p < 8; p++) begin
         if (p < int'(pad_remaining_bytes))
            pad_data_out[63-8*p -: 8] = pad_data_in[63-8*p -: 8];
         else if (pad_enable && !gen_latched && p == int'(pad_remaining_bytes))
            pad_data_out[63-8*p -: 8] = 8'h1F;
      end
      if ((pad_enable || gen_latched) && pad_last_word)
         pad_data_out[7:0] = pad_data_out[7:0] | 8'h80;
   end
   always_ff @(posedge clk) begin
      if (pad_reset)                       gen_latched <= 1'b0;
      else if (absorb_valid && pad_enable) gen_latched <= 1'b1;
   end

   typedef struct {
      int          idx;
      logic [63:0] data;
   } lane_t;
   lane_t       exp_q[$];
   logic [63:0] msg_words[$];

   always @(negedge clk) begin
      if (!rst && absorb_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_lane", 64'(absorb_idx), 64'hFFFF);
         end else begin
            lane_t e;
            e = exp_q.pop_front();
            check("lane_idx", 64'(absorb_idx), 64'(e.idx));
            check("lane_data", absorb_data, e.data);
            check("last_word_flag", 64'(pad_last_word), 64'(e.idx == RW - 1));
         end
      end
   end

   // Permutation responder; also pulses perm_done in the start cycle, which must be ignored.
   always @(negedge clk) begin
      if (perm_start) begin
         int lat;
         n_perm++;
         perm_done = 1'b1;
         @(negedge clk);
         perm_done = 1'b0;
         check("perm_start_one_cycle", 64'(perm_start), 64'd0);
         check("ready_in_perm", 64'(in_ready), 64'd0);
         lat = $urandom_range(0, 4);
         repeat (lat) begin
            @(negedge clk);
            check("ready_in_perm_wait", 64'(in_ready), 64'd0);
         end
         perm_done = 1'b1;
         @(negedge clk);
         perm_done = 1'b0;
      end
   end

   task automatic build_expected(input int n, input int last_bytes, output int nblocks);
      logic [7:0] bytes[$];
      for (int i = 0; i < n; i++) begin
         int nb;
         logic [63:0] wd;
         wd = msg_words[i];
         nb = (i == n - 1) ? last_bytes : 8;
         for (int p = 0; p < nb; p++) bytes.push_back(wd[63-8*p -: 8]);
      end
      bytes.push_back(8'h1F);
      while (bytes.size() % RB != 0) bytes.push_back(8'h00);
      bytes[bytes.size()-1] = bytes[bytes.size()-1] | 8'h80;
      nblocks = bytes.size() / RB;
      for (int k = 0; k < bytes.size() / 8; k++) begin
         lane_t e;
         e.idx  = k % RW;
         e.data = '0;
         for (int p = 0; p < 8; p++) e.data[63-8*p -: 8] = bytes[8*k+p];
         exp_q.push_back(e);
      end
   endtask

   task automatic drive_words(input int n, input int last_bytes, input bit gaps);
      for (int i = 0; i < n; i++) begin
         int cnt;
         bit ok;
         if (gaps) begin
            int g;
            in_valid = 1'b0;
            g = $urandom_range(0, 2);
            repeat (g) begin
               @(posedge clk);
               #1;
            end
         end
         in_valid = 1'b1;
         in_data  = msg_words[i];
         in_last  = (i == n - 1);
         in_bytes = in_last ? 4'(last_bytes) : 4'($urandom_range(0, 15));
         next_msg = 1'($urandom_range(0, 1));
         cnt = 0;
         ok  = 1'b0;
         while (!ok && cnt < 300) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            cnt++;
         end
         if (!ok) check("handshake_timeout", 64'd0, 64'd1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      next_msg = 1'b0;
      in_data  = {$urandom, $urandom};
   endtask

   task automatic send_msg(input int n, input int last_bytes, input bit gaps);
      int nblocks;
      int p0;
      int cnt;
      msg_words.delete();
      for (int i = 0; i < n; i++) msg_words.push_back({$urandom, $urandom});
      build_expected(n, last_bytes, nblocks);
      p0 = n_perm;
      drive_words(n, last_bytes, gaps);
      cnt = 0;
      @(negedge clk);
      while (!absorb_done && cnt < 2000) begin
         @(negedge clk);
         cnt++;
      end
      check("absorb_done", 64'(absorb_done), 64'd1);
      check("lanes_pending", 64'(exp_q.size()), 64'd0);
      check("perm_count", 64'(n_perm - p0), 64'(nblocks));
      @(negedge clk);
      check("done_held", 64'(absorb_done), 64'd1);
      check("ready_in_done", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      next_msg = 1'b1;
      @(negedge clk);
      check("pad_reset_pulse", 64'(pad_reset), 64'd1);
      @(posedge clk);
      #1;
      next_msg = 1'b0;
      @(negedge clk);
      check("done_released", 64'(absorb_done), 64'd0);
      check("ready_after_release", 64'(in_ready), 64'd1);
      check("pad_reset_low", 64'(pad_reset), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_bytes  = '0;
      in_last   = 1'b0;
      perm_done = 1'b0;
      next_msg  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_absorb_valid", 64'(absorb_valid), 64'd0);
      check("rst_perm_start", 64'(perm_start), 64'd0);
      check("rst_absorb_done", 64'(absorb_done), 64'd0);
      check("rst_pad_enable", 64'(pad_enable), 64'd0);
      check("rst_pad_reset", 64'(pad_reset), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_idx", 64'(absorb_idx), 64'd0);
      check("post_rst_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      send_msg(1, 3, 1'b0);
      send_msg(RW, 7, 1'b0);
      send_msg(RW, 8, 1'b0);
      send_msg(1, 0, 1'b0);
      send_msg(RW - 1, 8, 1'b1);
      send_msg(RW + 3, 2, 1'b1);

      // Abort in PAD at word index 9: nine full words absorbed raw, padding cut short.
      msg_words.delete();
      for (int i = 0; i < 9; i++) begin
         lane_t e;
         msg_words.push_back({$urandom, $urandom});
         e.idx  = i;
         e.data = msg_words[i];
         exp_q.push_back(e);
      end
      drive_words(9, 8, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("abort_ready", 64'(in_ready), 64'd1);
      check("abort_valid", 64'(absorb_valid), 64'd0);
      check("abort_pad_reset", 64'(pad_reset), 64'd1);
      check("abort_pad_enable", 64'(pad_enable), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("after_abort_ready", 64'(in_ready), 64'd1);
      check("after_abort_idx", 64'(absorb_idx), 64'd0);
      check("after_abort_done", 64'(absorb_done), 64'd0);
      check("after_abort_pending", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
      send_msg(2, 5, 1'b1);

      for (int m = 0; m < 10; m++) begin
         send_msg($urandom_range(1, 2 * RW + 3), $urandom_range(0, 8), 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
